// File: rtl/lvt_port_arbiter_if.sv
// Requester handshake, read response and memory-port bundle for lvt_port_arbiter.
// master = arbiter side, slave = requesters plus memory array.
interface lvt_port_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PORTS = 4,
  parameter int REQS  = 6
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REQS-1:0]             req_valid;
  logic [REQS-1:0]             req_we;
  logic [REQS-1:0][AW-1:0]     req_addr;
  logic [REQS-1:0][WIDTH-1:0]  req_wdata;
  logic [REQS-1:0]             req_ready;
  logic [REQS-1:0]             rsp_valid;
  logic [REQS-1:0][WIDTH-1:0]  rsp_data;
  logic [PORTS-1:0][AW-1:0]    mem_addr;
  logic [PORTS-1:0]            mem_en;
  logic [PORTS-1:0][WIDTH-1:0] mem_d;
  logic [PORTS-1:0][WIDTH-1:0] mem_q;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_data, mem_addr, mem_en, mem_d
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_data, mem_addr, mem_en, mem_d
  );
endinterface

// File: rtl/lvt_port_arbiter.sv
// Round-robin arbiter mapping up to PORTS requests per cycle onto an LVT memory,
// with same-address conflict filtering and one-cycle read data return.
module lvt_port_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PORTS = 4,
  parameter int REQS  = 6
) (
  input logic                clk,
  input logic                rst,
  lvt_port_arbiter_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (REQS > 1) ? $clog2(REQS) : 1;
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [RW-1:0]               rr_ptr;
  logic [RW-1:0]               last_gnt;
  logic [RW-1:0]               idx;
  logic [RW:0]                 sum;
  logic [PW:0]                 cnt;
  logic                        ok;
  logic                        any_gnt;
  logic [REQS-1:0]             grant;
  logic [REQS-1:0]             pend_rd;
  logic [REQS-1:0][PW-1:0]     gport;
  logic [REQS-1:0][PW-1:0]     pend_port;
  logic [PORTS-1:0][AW-1:0]    p_addr;
  logic [PORTS-1:0]            p_en;
  logic [PORTS-1:0][WIDTH-1:0] p_d;
  logic [REQS-1:0][WIDTH-1:0]  rsp_d;

  // Slots 0..cnt-1 of p_addr/p_en hold the requests already granted this cycle,
  // so they double as the conflict table for later requesters in the scan.
  always_comb begin
    grant    = '0;
    gport    = '0;
    last_gnt = '0;
    any_gnt  = 1'b0;
    cnt      = '0;
    idx      = '0;
    sum      = '0;
    ok       = 1'b0;
    p_addr   = '0;
    p_en     = '0;
    p_d      = '0;
    if (!rst) begin
      for (int i = 0; i < REQS; i++) begin
        sum = {1'b0, rr_ptr} + (RW+1)'(i);
        if (sum >= (RW+1)'(REQS)) sum = sum - (RW+1)'(REQS);
        idx = sum[RW-1:0];
        ok  = bus.req_valid[idx] && (cnt < (PW+1)'(PORTS));
        for (int k = 0; k < PORTS; k++) begin
          if (((PW+1)'(k) < cnt) && (p_addr[k] == bus.req_addr[idx]) &&
              (bus.req_we[idx] || p_en[k]))
            ok = 1'b0;
        end
        if (ok) begin
          grant[idx]          = 1'b1;
          gport[idx]          = cnt[PW-1:0];
          p_addr[cnt[PW-1:0]] = bus.req_addr[idx];
          p_en[cnt[PW-1:0]]   = bus.req_we[idx];
          p_d[cnt[PW-1:0]]    = bus.req_we[idx] ? bus.req_wdata[idx] : '0;
          last_gnt            = idx;
          any_gnt             = 1'b1;
          cnt                 = cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < REQS; r++)
      rsp_d[r] = pend_rd[r] ? bus.mem_q[pend_port[r]] : '0;
  end

  assign bus.req_ready = grant;
  assign bus.mem_addr  = p_addr;
  assign bus.mem_en    = p_en;
  assign bus.mem_d     = p_d;
  assign bus.rsp_valid = pend_rd;
  assign bus.rsp_data  = rsp_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      pend_rd   <= '0;
      pend_port <= '0;
    end else begin
      if (any_gnt)
        rr_ptr <= (last_gnt == RW'(REQS - 1)) ? '0 : last_gnt + 1'b1;
      for (int r = 0; r < REQS; r++) begin
        pend_rd[r] <= grant[r] && !bus.req_we[r];
        if (grant[r] && !bus.req_we[r])
          pend_port[r] <= gport[r];
      end
    end
  end
endmodule
